// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared helpers for the mac cell: accumulator width and signed clamp
package mac_pkg;

    function automatic int acc_width(input int op_w, input int guard);
        return 2 * op_w + guard;
    endfunction

    // Clamp a sign-extended value into the signed range of `width` bits.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/sat_clamp.sv
// rtl/sat_clamp.sv - combinational signed saturation from iw bits down to ow bits
module sat_clamp
    import mac_pkg::*;
#(
    parameter int iw = 19,
    parameter int ow = 18
) (
    input  logic [iw-1:0] din,
    output logic [ow-1:0] dout
);

    always_comb begin
        dout = ow'(sat_to(64'($signed(din)), ow));
    end

endmodule

// File: rtl/mac.sv
// rtl/mac.sv - signed fixed-point multiply-accumulate cell with saturating accumulator and output
module mac
    import mac_pkg::*;
#(
    parameter int w  = 8,
    parameter int fb = w - 2,
    parameter int g  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [w-1:0] x,
    input  logic [w-1:0] c,
    output logic [w-1:0] o
);

    localparam int aw = acc_width(w, g);

    logic signed [aw-1:0]  acc;
    logic signed [2*w-1:0] p;
    logic signed [aw:0]    sum;
    logic [aw-1:0]         acc_next;
    logic signed [aw-1:0]  s;

    assign p   = (2*w)'($signed(x)) * (2*w)'($signed(c));
    // One extra bit so the sum itself can never wrap before clamping.
    assign sum = (aw+1)'(acc) + (aw+1)'(p);

    sat_clamp #(.iw(aw + 1), .ow(aw)) u_acc_clamp (
        .din  (sum),
        .dout (acc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= $signed(acc_next);
        end
    end

    // Floor toward -inf back to operand format; acc keeps full precision.
    assign s = acc >>> fb;

    sat_clamp #(.iw(aw), .ow(w)) u_out_clamp (
        .din  (s),
        .dout (o)
    );

endmodule

// File: tb/tb_mac.sv
// tb/tb_mac.sv - randomized and directed self-checking bench for mac (w=5, fb=3, g=8)
module tb_mac;

    localparam int W  = 5;
    localparam int FB = 3;
    localparam int G  = 8;
    localparam longint ACC_MAX = (64'sd1 <<< (2*W + G - 1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (2*W + G - 1));

    logic         clk;
    logic         rst;
    logic [W-1:0] x;
    logic [W-1:0] c;
    logic [W-1:0] o;

    int passed = 0;
    int total  = 0;

    longint acc_m = 0;

    mac #(.w(W), .fb(FB), .g(G)) dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .c   (c),
        .o   (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint clampl(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int model_o();
        longint q;
        q = acc_m / (64'sd1 <<< FB);
        if (acc_m < 0 && (acc_m % (64'sd1 <<< FB)) != 0) q = q - 1;
        return int'(clampl(q, -(64'sd1 <<< (W-1)), (64'sd1 <<< (W-1)) - 1));
    endfunction

    function automatic longint dut_acc();
        return longint'(dut.acc);
    endfunction

    task automatic cyc(input logic r, input int xv, input int cv);
        @(negedge clk);
        rst = r;
        x   = W'(xv);
        c   = W'(cv);
        @(posedge clk);
        #1;
        if (r) acc_m = 0;
        else   acc_m = clampl(acc_m + longint'(xv) * longint'(cv), ACC_MIN, ACC_MAX);
    endtask

    task automatic test_reset();
        cyc(1'b1, 7, 7);
        total++;
        if (o !== 5'b00000) $display("FAIL reset_o o=%0d required=0", $signed(o));
        else passed++;
        cyc(1'b0, 0, 0);
        total++;
        if (o !== 5'b00000) $display("FAIL zero_op_o o=%0d required=0", $signed(o));
        else passed++;
        total++;
        if (dut_acc() !== 0) $display("FAIL zero_op_acc acc=%0d required=0", dut_acc());
        else passed++;
    endtask

    task automatic test_sequence();
        int xs[3] = '{4, 6, -4};
        int cs[3] = '{-3, -1, -3};
        int os[3] = '{-2, -3, -1};
        longint as[3] = '{-12, -18, -6};
        cyc(1'b1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, xs[i], cs[i]);
            total++;
            if ($signed(o) !== os[i]) $display("FAIL seq_o[%0d] o=%0d required=%0d", i, $signed(o), os[i]);
            else passed++;
            total++;
            if (dut_acc() !== as[i]) $display("FAIL seq_acc[%0d] acc=%0d required=%0d", i, dut_acc(), as[i]);
            else passed++;
        end
    endtask

    task automatic test_out_sat();
        cyc(1'b1, 0, 0);
        cyc(1'b0, -16, -16);
        total++;
        if ($signed(o) !== 15) $display("FAIL out_sat_hi o=%0d required=15", $signed(o));
        else passed++;
        cyc(1'b0, -16, 15);
        total++;
        if ($signed(o) !== 2) $display("FAIL out_sat_recover o=%0d required=2", $signed(o));
        else passed++;
        total++;
        if (dut_acc() !== 16) $display("FAIL out_sat_acc acc=%0d required=16", dut_acc());
        else passed++;
    endtask

    task automatic test_neg_sat();
        cyc(1'b1, 0, 0);
        cyc(1'b0, -16, 15);
        cyc(1'b0, -16, 15);
        total++;
        if ($signed(o) !== -16) $display("FAIL neg_sat_o o=%0d required=-16", $signed(o));
        else passed++;
        total++;
        if (dut_acc() !== -480) $display("FAIL neg_sat_acc acc=%0d required=-480", dut_acc());
        else passed++;
        cyc(1'b0, 15, 15);
        total++;
        if (dut_acc() !== -255) $display("FAIL neg_sat_later_acc acc=%0d required=-255", dut_acc());
        else passed++;
        total++;
        if ($signed(o) !== -16) $display("FAIL neg_sat_later_o o=%0d required=-16", $signed(o));
        else passed++;
    endtask

    task automatic test_acc_clamp();
        cyc(1'b1, 0, 0);
        for (int i = 0; i < 520; i++) cyc(1'b0, -16, -16);
        total++;
        if (dut_acc() !== 131071) $display("FAIL acc_clamp_hi acc=%0d required=131071", dut_acc());
        else passed++;
        total++;
        if ($signed(o) !== 15) $display("FAIL acc_clamp_o o=%0d required=15", $signed(o));
        else passed++;
        cyc(1'b0, -16, 15);
        total++;
        if (dut_acc() !== 130831) $display("FAIL acc_clamp_back acc=%0d required=130831", dut_acc());
        else passed++;
    endtask

    task automatic test_mid_reset();
        cyc(1'b1, 0, 0);
        cyc(1'b0, 7, 7);
        cyc(1'b0, 5, 3);
        cyc(1'b1, 7, 7);
        total++;
        if (o !== 5'b00000) $display("FAIL mid_reset_o o=%0d required=0", $signed(o));
        else passed++;
        cyc(1'b0, 0, 0);
        total++;
        if (dut_acc() !== 0) $display("FAIL mid_reset_fresh acc=%0d required=0", dut_acc());
        else passed++;
    endtask

    task automatic test_random();
        int xv;
        int cv;
        logic r;
        int bad_o = 0;
        int bad_a = 0;
        cyc(1'b1, 0, 0);
        for (int i = 0; i < 300; i++) begin
            xv = int'($urandom_range(0, 31)) - 16;
            cv = int'($urandom_range(0, 31)) - 16;
            r  = ($urandom_range(0, 19) == 0);
            cyc(r, xv, cv);
            total++;
            if ($signed(o) !== model_o()) begin
                if (bad_o < 5) $display("FAIL rand_o[%0d] o=%0d required=%0d", i, $signed(o), model_o());
                bad_o++;
            end else passed++;
            total++;
            if (dut_acc() !== acc_m) begin
                if (bad_a < 5) $display("FAIL rand_acc[%0d] acc=%0d required=%0d", i, dut_acc(), acc_m);
                bad_a++;
            end else passed++;
        end
    endtask

    initial begin
        rst = 1'b1;
        x   = '0;
        c   = '0;
        test_reset();
        test_sequence();
        test_out_sat();
        test_neg_sat();
        test_acc_clamp();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
